// File: rtl/generic_2clk_fifo_rd_prefetch_pkg.sv
// Shared constants and helpers for the dual-clock FIFO read-side prefetch buffer.
package generic_2clk_fifo_rd_prefetch_pkg;

    localparam int DAT_WIDTH_DEF = 50;
    localparam int BUF_DEPTH_DEF = 3;
    localparam int BUF_LVL_W     = 2;

    typedef logic [BUF_LVL_W-1:0] lvl_t;
    typedef logic [1:0]           ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH_DEF - 1)) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/generic_reg_fifo3.sv
// Three-entry register queue: push at tail, pop from head, occupancy level out.
module generic_reg_fifo3
    import generic_2clk_fifo_rd_prefetch_pkg::*;
#(
    parameter int W = DAT_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output lvl_t         o_level
);

    logic [W-1:0] r_mem [BUF_DEPTH_DEF];
    ptr_t         r_wr_ptr;
    ptr_t         r_rd_ptr;
    lvl_t         r_level;
    logic         w_full;
    logic         w_pop_ok;
    logic         w_push_ok;

    assign w_full    = (r_level == lvl_t'(BUF_DEPTH_DEF));
    assign w_pop_ok  = i_pop && (r_level != '0);
    // a push into a full queue only lands if the head leaves in the same cycle
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_level <= r_level + lvl_t'(w_push_ok) - lvl_t'(w_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/generic_2clk_fifo_rd_prefetch.sv
// Read-side prefetch: issues FIFO reads ahead of demand so the 1-cycle memory
// latency is hidden and one word per cycle can be delivered downstream.
module generic_2clk_fifo_rd_prefetch
    import generic_2clk_fifo_rd_prefetch_pkg::*;
#(
    parameter int DAT_WIDTH = DAT_WIDTH_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic                 rd_clk,
    input  logic                 rd_reset,
    output logic                 fifo_rd_op,
    input  logic                 fifo_rd_empty,
    input  logic [DAT_WIDTH-1:0] fifo_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DAT_WIDTH-1:0] out_data,
    output logic [1:0]           buf_level,
    output logic                 ovf_err
);

    logic                 r_inflight;
    logic                 r_hold;
    logic                 r_ovf;
    lvl_t                 w_level;
    logic [2:0]           w_occ;
    logic                 w_xfer;
    logic [DAT_WIDTH-1:0] w_head;

    generic_reg_fifo3 #(.W(DAT_WIDTH)) u_buf (
        .clk     (rd_clk),
        .rst     (rd_reset),
        .i_push  (r_inflight),
        .i_pop   (w_xfer),
        .i_wdata (fifo_rd_data),
        .o_rdata (w_head),
        .o_level (w_level)
    );

    // counting the in-flight read as occupied guarantees the return always has room
    assign w_occ      = {1'b0, w_level} + {2'b00, r_inflight};
    assign fifo_rd_op = !fifo_rd_empty && !r_hold && (w_occ < 3'(BUF_DEPTH));
    assign out_valid  = (w_level != '0);
    assign w_xfer     = out_valid && out_ready;

    // r_hold masks issue from reset until the first clock edge after release
    always_ff @(posedge rd_clk or posedge rd_reset) begin
        if (rd_reset) begin
            r_inflight <= 1'b0;
            r_hold     <= 1'b1;
            r_ovf      <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_op;
            r_hold     <= 1'b0;
            if (r_inflight && (w_level == lvl_t'(BUF_DEPTH)) && !w_xfer)
                r_ovf <= 1'b1;
        end
    end

    assign out_data  = w_head;
    assign buf_level = w_level;
    assign ovf_err   = r_ovf;

endmodule

// File: tb/tb_generic_2clk_fifo_rd_prefetch.sv
// Directed scoreboard bench for the FIFO read prefetch buffer with a behavioural FIFO source.
module tb_generic_2clk_fifo_rd_prefetch;

    localparam int DW = 50;

    logic          rd_clk = 1'b0;
    logic          rd_reset = 1'b1;
    logic          fifo_rd_op;
    logic          fifo_rd_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    buf_level;
    logic          ovf_err;

    always #5 rd_clk = ~rd_clk;

    generic_2clk_fifo_rd_prefetch #(.DAT_WIDTH(DW), .BUF_DEPTH(3)) dut (
        .rd_clk        (rd_clk),
        .rd_reset      (rd_reset),
        .fifo_rd_op    (fifo_rd_op),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_data  (fifo_rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .buf_level     (buf_level),
        .ovf_err       (ovf_err)
    );

    // behavioural FIFO: empty reflects a read in the previous cycle, data returns 1 cycle after the strobe
    logic [DW-1:0] src_mem [256];
    int            src_wr = 0;
    int            src_rd = 0;
    logic          src_flush = 1'b0;

    assign fifo_rd_empty = (src_wr == src_rd);

    always @(posedge rd_clk) begin
        if (src_flush) begin
            src_rd <= src_wr;
        end else if (fifo_rd_op) begin
            fifo_rd_data <= src_mem[src_rd];
            src_rd       <= src_rd + 1;
        end
    end

    logic [DW-1:0] exp_q [$];
    int            n_vec  = 0;
    int            n_err  = 0;
    int            n_xfer = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        src_mem[src_wr] = w;
        src_wr++;
        exp_q.push_back(w);
    endtask

    task automatic cyc_start();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge rd_clk);
    endtask

    // monitor: pops the scoreboard on every transfer and checks stall stability
    logic          last_stall = 1'b0;
    logic [DW-1:0] last_data;

    always @(negedge rd_clk) begin
        if (last_stall && out_valid) chk("stall_hold", out_data, last_data);
        if (out_valid && out_ready) begin
            n_xfer++;
            chk("xfer_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
        end
        last_stall = out_valid && !out_ready && !rd_reset;
        last_data  = out_data;
    end

    initial begin
        int cnt;
        int x0;

        // reset, then FIFO held empty
        mid();
        chk("rst_rd_op", fifo_rd_op, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", buf_level, 0);
        chk("rst_ovf", ovf_err, 0);
        cyc_start();
        rd_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mid();
            chk("idle_rd_op", fifo_rd_op, 0);
            chk("idle_valid", out_valid, 0);
            chk("idle_level", buf_level, 0);
            cyc_start();
        end

        // four words, ready high: latency and streaming
        out_ready = 1'b1;
        push_word(50'h0_0000_000A);
        push_word(50'h0_0000_000B);
        push_word(50'h0_0000_000C);
        push_word(50'h0_0000_000D);
        for (int c = 0; c < 8; c++) begin
            mid();
            chk("abcd_rd_op", fifo_rd_op, (c <= 3));
            chk("abcd_valid", out_valid, (c >= 2 && c <= 5));
            cyc_start();
        end
        chk("abcd_drained", exp_q.size(), 0);
        chk("abcd_level", buf_level, 0);

        // ten words with downstream stalled, then released
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_word(50'h3_5A00_0100 + 50'(i));
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            mid();
            cnt += int'(fifo_rd_op);
            cyc_start();
        end
        chk("stall_pulses", cnt, 3);
        chk("stall_level", buf_level, 3);
        chk("stall_ovf", ovf_err, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            mid();
            chk("burst_no_gap", out_valid, 1);
            cyc_start();
        end
        for (int c = 0; c < 3; c++) cyc_start();
        chk("burst_drained", exp_q.size(), 0);
        chk("burst_level", buf_level, 0);
        chk("burst_ovf", ovf_err, 0);

        // toggling ready with a continuous supply
        for (int i = 0; i < 12; i++) push_word(50'h1_C300_0200 + 50'(i * 7));
        for (int c = 0; c < 30; c++) begin
            out_ready = (c % 2 == 0);
            mid();
            cyc_start();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) cyc_start();
        chk("toggle_drained", exp_q.size(), 0);
        chk("toggle_ovf", ovf_err, 0);
        chk("toggle_level", buf_level, 0);

        // reset with two buffered words and one read in flight
        out_ready = 1'b0;
        push_word(50'h2_0000_0301);
        push_word(50'h2_0000_0302);
        push_word(50'h2_0000_0303);
        for (int c = 0; c < 3; c++) cyc_start();
        mid();
        chk("pre_rst_level", buf_level, 2);
        chk("pre_rst_rd_op", fifo_rd_op, 0);
        rd_reset = 1'b1;
        mid();
        chk("in_rst_rd_op", fifo_rd_op, 0);
        chk("in_rst_valid", out_valid, 0);
        chk("in_rst_level", buf_level, 0);
        chk("in_rst_ovf", ovf_err, 0);
        exp_q.delete();
        src_flush = 1'b1;
        cyc_start();
        src_flush = 1'b0;
        push_word(50'h2_0000_0399);
        cyc_start();
        rd_reset = 1'b0;
        mid();
        chk("post_rst_first_op", fifo_rd_op, 0);
        cyc_start();
        mid();
        chk("post_rst_second_op", fifo_rd_op, 1);
        cyc_start();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cyc_start();
        chk("post_rst_drained", exp_q.size(), 0);
        chk("post_rst_level", buf_level, 0);

        // single word
        x0  = n_xfer;
        cnt = 0;
        push_word(50'h0_F00D_0001);
        for (int c = 0; c < 8; c++) begin
            mid();
            cnt += int'(fifo_rd_op);
            cyc_start();
        end
        chk("single_rd_ops", cnt, 1);
        chk("single_xfers", n_xfer - x0, 1);
        chk("single_level", buf_level, 0);
        chk("single_valid", out_valid, 0);
        chk("final_ovf", ovf_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
